uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised, runtime-configurable UART transmitter; successor to the fixed 8-bit/even-parity TX.
//  Adds generic data width, built-in baud divider, parity none/even/odd, 1 or 2 stop bits,
//  and a valid/ready input handshake. Sits between the TX FIFO (or register interface) and the pad.
// PARAMETERS
//  DATA_SIZE     8   data bits per frame, legal 5..9, sent LSB first
//  CLKS_PER_BIT  16  clk cycles per serial bit, legal >= 2
//  DIV_W  $clog2(CLKS_PER_BIT)  baud counter width (derived, do not override)
//  CNT_W  $clog2(DATA_SIZE)     data-bit index width (derived, do not override)
// PORTS
//  clk              in   1          clock, all logic on rising edge
//  reset_n          in   1          synchronous reset, active low
//  tx_valid         in   1          data_in/config valid
//  tx_ready         out  1          block can accept a frame (high only in IDLE)
//  data_in          in   DATA_SIZE  frame payload
//  parity_mode      in   2          00 none, 01 even, 10 odd, 11 treated as none
//  stop_bits        in   1          0 = one stop bit, 1 = two stop bits
//  serial_data_out  out  1          UART line, idle high, registered
//  tx_busy          out  1          frame in progress (state != IDLE)
//  tx_done          out  1          one-cycle pulse after last stop bit completes
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state=IDLE, serial_data_out=1, tx_ready=1, tx_busy=0,
//   tx_done=0, baud and bit counters=0. Reset mid-frame aborts it; line high next cycle.
//  Handshake: transfer when tx_valid & tx_ready on a clk edge. data_in, parity_mode, stop_bits
//   latched on that edge; input changes during the frame are ignored. tx_valid in non-IDLE: no effect.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: line 1; on transfer -> START.
//   START: line 0 for CLKS_PER_BIT cycles -> DATA.
//   DATA: bit i (i=0..DATA_SIZE-1) for CLKS_PER_BIT cycles each; after last -> PARITY if
//    latched mode is 01/10, else STOP.
//   PARITY: even -> ^data; odd -> ~^data; held CLKS_PER_BIT cycles -> STOP.
//   STOP: line 1 for CLKS_PER_BIT (x2 if stop_bits=1) cycles -> IDLE, asserting tx_done.
//  Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state, wraps to 0 at bit end;
//   held at 0 in IDLE. No external tick.
//  Timing: transfer at edge k -> line low from cycle k+1. F = 1+DATA_SIZE+P+S bits
//   (P = 0/1, S = 1/2). Frame occupies cycles k+1..k+F*CLKS_PER_BIT; tx_done=1, tx_ready=1,
//   line 1 in cycle k+F*CLKS_PER_BIT+1 exactly.
//  Back-to-back: tx_valid held high -> next transfer on the tx_done cycle; minimum inter-frame
//   gap = 1 clk of idle high.
//  tx_busy = ~tx_ready at all times. tx_done never asserts for an aborted frame.
// TESTING  (DATA_SIZE=8, CLKS_PER_BIT=4 unless stated)
//  8N1 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each 4 clks; tx_done exactly 41 clks after transfer.
//  8E2 0x07 -> start, 1,1,1,0,0,0,0,0, parity 1, stop 1,1; tx_done at transfer+49.
//  8O1 0x00 -> parity bit 1; mode 11 with 0x00 -> no parity bit, tx_done at transfer+41.
//  tx_valid held high, 0x55 then 0xAA -> second transfer on tx_done cycle; one idle-high clk between.
//  reset_n low during DATA bit 3 -> next cycle line 1, tx_ready 1, no tx_done; new frame sends cleanly.
//  Change data_in/parity_mode/stop_bits mid-frame and pulse tx_valid -> frame unchanged, no 2nd accept.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: N data bits, optional parity,
// one or two stop bits, built-in baud divider and valid/ready input.
module uart_tx_cfg #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_W        = $clog2(CLKS_PER_BIT),
  parameter int CNT_W        = $clog2(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  output logic                 serial_data_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [DIV_W-1:0] BAUD_LAST =
    DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST =
    CNT_W'(DATA_SIZE - 1);
  localparam logic [CNT_W-1:0] BIT_ONE = CNT_W'(1);

  state_t               r_state;
  logic [DIV_W-1:0]     r_baud;
  logic [CNT_W-1:0]     r_bit;
  logic [DATA_SIZE-1:0] r_data;
  logic [1:0]           r_pmode;
  logic                 r_stop2;
  logic                 r_line;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [DIV_W-1:0]     w_baud_nxt;
  logic [CNT_W-1:0]     w_bit_nxt;
  logic                 w_line_nxt;
  logic                 w_done_nxt;
  logic                 w_idle;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_par_en;
  logic                 w_par_bit;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = tx_valid & w_idle;
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_par_en  = (r_pmode == 2'b01) |
                     (r_pmode == 2'b10);
  assign w_par_bit = (r_pmode == 2'b10) ?
                     ~^r_data : ^r_data;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_done_nxt  = 1'b0;
    w_baud_nxt  = (w_idle | w_bit_end) ?
                  '0 : r_baud + DIV_W'(1);
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_bit_nxt   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == BIT_LAST) begin
            w_state_nxt = w_par_en ? S_PARITY : S_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
        end
      end
      S_STOP: begin
        // r_bit counts stop bits already sent
        if (w_bit_end) begin
          if (r_stop2 && (r_bit == '0)) begin
            w_bit_nxt = BIT_ONE;
          end else begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Line is registered: drive the level of the state being entered
  always_comb begin
    w_line_nxt = 1'b1;
    unique case (w_state_nxt)
      S_START:  w_line_nxt = 1'b0;
      S_DATA:   w_line_nxt = r_data[w_bit_nxt];
      S_PARITY: w_line_nxt = w_par_bit;
      default:  w_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_pmode <= 2'b00;
      r_stop2 <= 1'b0;
      r_line  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_line  <= w_line_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_data  <= data_in;
        r_pmode <= parity_mode;
        r_stop2 <= stop_bits;
      end
    end
  end

  assign tx_ready        = w_idle;
  assign tx_busy         = ~w_idle;
  assign serial_data_out = r_line;
  assign tx_done         = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: random frames against a
// bit-list reference model, checked cycle by cycle on the line.
module tb_uart_tx_cfg;

  localparam int DS  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DS-1:0] data_in = '0;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop_bits = 1'b0;
  logic          tx_ready;
  logic          serial_data_out;
  logic          tx_busy;
  logic          tx_done;

  uart_tx_cfg #(
    .DATA_SIZE   (DS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .data_in        (data_in),
    .parity_mode    (parity_mode),
    .stop_bits      (stop_bits),
    .serial_data_out(serial_data_out),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] bits;
    int          nb;
    int          k;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   mon_active = 1'b0;
  int   idx = 0;
  int   done_due = -1;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h",
               nm, cyc, got, exp);
    end
  endtask

  // Frame as the list of line levels, one entry per bit time
  function automatic exp_t model(input logic [DS-1:0] d,
                                 input logic [1:0] pm,
                                 input logic sb,
                                 input int k);
    exp_t m;
    int ones;
    m.bits = '0;
    m.nb = 0;
    m.k = k;
    ones = $countones(d);
    m.bits[m.nb] = 1'b0;
    m.nb++;
    for (int i = 0; i < DS; i++) begin
      m.bits[m.nb] = d[i];
      m.nb++;
    end
    if (pm == 2'b01) begin
      m.bits[m.nb] = (ones % 2 == 1);
      m.nb++;
    end else if (pm == 2'b10) begin
      m.bits[m.nb] = (ones % 2 == 0);
      m.nb++;
    end
    m.bits[m.nb] = 1'b1;
    m.nb++;
    if (sb) begin
      m.bits[m.nb] = 1'b1;
      m.nb++;
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      mon_active = 1'b0;
      done_due = -1;
      chk("rst_line", serial_data_out, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_done", tx_done, 0);
      chk("rst_busy", tx_busy, 0);
    end else begin
      chk("busy_xor_ready", tx_busy ^ tx_ready, 1);
      chk("done", tx_done, (cyc == done_due));
      if (!mon_active && serial_data_out === 1'b0) begin
        chk("frame_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("start_cyc", cyc, cur.k);
          mon_active = 1'b1;
          idx = 0;
        end
      end
      if (mon_active) begin
        chk("line", serial_data_out, cur.bits[idx / CPB]);
        chk("ready_in_frame", tx_ready, 0);
        idx++;
        if (idx == cur.nb * CPB) begin
          mon_active = 1'b0;
          done_due = cyc + 1;
        end
      end else begin
        chk("idle_line", serial_data_out, 1);
        chk("idle_ready", tx_ready, 1);
      end
    end
  end

  task automatic send(input logic [DS-1:0] d,
                      input logic [1:0] pm,
                      input logic sb,
                      input bit hold,
                      output int k);
    bit ok;
    ok = 1'b0;
    k = -1;
    @(negedge clk);
    #1;
    data_in = d;
    parity_mode = pm;
    stop_bits = sb;
    tx_valid = 1'b1;
    for (int n = 0; n < 500 && !ok; n++) begin
      if (tx_ready) begin
        k = cyc + 1;
        exp_q.push_back(model(d, pm, sb, k));
        ok = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    chk("accepted", ok, 1);
    if (ok) begin
      @(posedge clk);
      #1;
      tx_valid = hold;
    end else begin
      tx_valid = 1'b0;
    end
  endtask

  // Disturb inputs while busy; valid only while not ready
  task automatic scribble(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (tx_ready) break;
      data_in = DS'($urandom);
      parity_mode = 2'($urandom);
      stop_bits = 1'($urandom);
      tx_valid = 1'($urandom);
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    int k;
    int k1;
    int k2;
    logic [DS-1:0] d;
    logic [1:0] pm;
    logic sb;
    bit hold;

    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;

    send(8'hA5, 2'b00, 1'b0, 1'b0, k);
    send(8'h07, 2'b01, 1'b1, 1'b0, k);
    send(8'h00, 2'b10, 1'b0, 1'b0, k);
    send(8'h00, 2'b11, 1'b0, 1'b0, k);

    send(8'h55, 2'b00, 1'b0, 1'b1, k1);
    send(8'hAA, 2'b00, 1'b0, 1'b0, k2);
    chk("b2b_start", k2, k1 + (1 + DS + 1) * CPB + 1);

    send(8'h3C, 2'b00, 1'b0, 1'b0, k);
    repeat (17) @(negedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    send(8'hC3, 2'b01, 1'b1, 1'b0, k);

    send(8'h96, 2'b10, 1'b1, 1'b0, k);
    scribble(30);

    for (int f = 0; f < 40; f++) begin
      d = DS'($urandom);
      pm = 2'($urandom);
      sb = 1'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      send(d, pm, sb, hold, k);
      if ($urandom_range(0, 2) == 0) begin
        scribble(20);
      end else if (!hold) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    @(negedge clk);
    #1;
    tx_valid = 1'b0;

    for (int n = 0; n < 300; n++) begin
      if (!mon_active && exp_q.size() == 0 &&
          cyc > done_due) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("drain_pending", exp_q.size() + int'(mon_active), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
